// File: rtl/regfile_wen_decoder_pkg.sv
// Shared types and defaults for the register-file write-enable decoder.
//   state_e        : FSM state encoding (CLEAR sweep / RUN decode)
//   DEFAULT_ADDR_W : default write-address width
package regfile_wen_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage : regfile_wen_pkg

// File: rtl/decoder_n.sv
// Generic combinational N-way decoder: sel/en -> one-hot vector.
// Ports:
//   sel      in  ADDR_W  index to decode
//   en       in  1       gate; 0 forces all-zero output
//   onehot_c out NREG    one-hot (or zero when en=0 or sel >= NREG)
module decoder_n #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] sel,
  input  logic              en,
  output logic [NREG-1:0]   onehot_c
);

  // Indices with no matching output bit simply produce zero.
  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      onehot_c[i] = en && (sel == ADDR_W'(i));
    end
  end

endmodule : decoder_n

// File: rtl/regfile_wen_decoder.sv
// Registered write-enable decoder for the register file, with a
// zero-register mask and an automatic clear sweep after reset / on request.
// Ports:
//   clk        in  1       system clock, rising edge
//   reset      in  1       asynchronous active-high reset
//   wr_addr    in  ADDR_W  register index to write
//   wr_en      in  1       write request
//   clr_req    in  1       request a full clear sweep
//   busy       out 1       high while sweeping (decoded from the state register)
//   en_out     out NREG    registered one-hot write enables
//   clr_active out 1       registered; marks sweep enables (select zero data)
//   wr_drop    out 1       registered pulse: a write request was discarded
module regfile_wen_decoder
  import regfile_wen_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NREG     = 2 ** ADDR_W,
  parameter int unsigned ZERO_IDX = NREG - 1,
  parameter int unsigned HAS_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              clr_req,
  output logic              busy,
  output logic [NREG-1:0]   en_out,
  output logic              clr_active,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_IDX);
  localparam logic              MASK_ON  = (HAS_ZERO != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]   en_out_q, en_out_d;
  logic              clr_active_q, clr_active_d;
  logic              wr_drop_q, wr_drop_d;

  logic [ADDR_W-1:0] dec_sel;
  logic              dec_en;
  logic [NREG-1:0]   dec_onehot;

  // Single decoder shared between the sweep counter and the write address.
  decoder_n #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_dec (
    .sel      (dec_sel),
    .en       (dec_en),
    .onehot_c (dec_onehot)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_sel      = wr_addr;
    dec_en       = 1'b0;
    clr_active_d = 1'b0;
    wr_drop_d    = 1'b0;

    unique case (state_q)
      CLEAR: begin
        // Sweep every register, including the zero register; clr_req ignored.
        dec_sel      = cnt_q;
        dec_en       = 1'b1;
        clr_active_d = 1'b1;
        wr_drop_d    = wr_en;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (clr_req) begin
          // Clear wins over a same-cycle write; that write must be retried.
          state_d   = CLEAR;
          cnt_d     = '0;
          wr_drop_d = wr_en;
        end else begin
          dec_en = wr_en && !(MASK_ON && (wr_addr == ZERO_A));
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase

    en_out_d = dec_onehot;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      en_out_q     <= '0;
      clr_active_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_out_q     <= en_out_d;
      clr_active_q <= clr_active_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign en_out     = en_out_q;
  assign clr_active = clr_active_q;
  assign wr_drop    = wr_drop_q;

endmodule : regfile_wen_decoder

// File: tb/tb_regfile_wen_decoder.sv
// Directed self-checking bench for regfile_wen_decoder (default and small config).
module tb_regfile_wen_decoder;

  logic        clk;
  logic        reset;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic        clr_req;
  logic        busy;
  logic [31:0] en_out;
  logic        clr_active;
  logic        wr_drop;

  logic        reset2;
  logic [2:0]  wr_addr2;
  logic        wr_en2;
  logic        clr_req2;
  logic        busy2;
  logic [5:0]  en_out2;
  logic        clr_active2;
  logic        wr_drop2;

  int checks;
  int errors;

  regfile_wen_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .clr_req    (clr_req),
    .busy       (busy),
    .en_out     (en_out),
    .clr_active (clr_active),
    .wr_drop    (wr_drop)
  );

  regfile_wen_decoder #(
    .ADDR_W   (3),
    .NREG     (6),
    .HAS_ZERO (0)
  ) dut_small (
    .clk        (clk),
    .reset      (reset2),
    .wr_addr    (wr_addr2),
    .wr_en      (wr_en2),
    .clr_req    (clr_req2),
    .busy       (busy2),
    .en_out     (en_out2),
    .clr_active (clr_active2),
    .wr_drop    (wr_drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    wr_addr  = '0;
    wr_en    = 1'b0;
    clr_req  = 1'b0;
    reset2   = 1'b1;
    wr_addr2 = '0;
    wr_en2   = 1'b0;
    clr_req2 = 1'b0;

    // Reset state
    #3;
    check("rst_en_out", 64'(en_out), 64'h0);
    check("rst_clr_active", 64'(clr_active), 64'h0);
    check("rst_wr_drop", 64'(wr_drop), 64'h0);
    check("rst_busy", 64'(busy), 64'h1);

    @(negedge clk);
    reset = 1'b0;

    // Post-reset sweep; a write at sweep cycle 10 is dropped without disturbing it
    for (int i = 0; i < 32; i++) begin
      wr_en   = (i == 9);
      wr_addr = 5'd2;
      step();
      check("sweep_en", 64'(en_out), 64'h1 << i);
      check("sweep_clr_active", 64'(clr_active), 64'h1);
      check("sweep_wr_drop", 64'(wr_drop), (i == 9) ? 64'h1 : 64'h0);
      check("sweep_busy", 64'(busy), (i == 31) ? 64'h0 : 64'h1);
    end
    wr_en = 1'b0;

    step();
    check("idle_en", 64'(en_out), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);
    check("idle_clr_active", 64'(clr_active), 64'h0);

    // RUN decode
    wr_en = 1'b1; wr_addr = 5'd5;
    step();
    check("wr5_en", 64'(en_out), 64'h20);
    check("wr5_clr_active", 64'(clr_active), 64'h0);
    check("wr5_drop", 64'(wr_drop), 64'h0);
    wr_addr = 5'd31;
    step();
    check("wr31_masked", 64'(en_out), 64'h0);
    check("wr31_drop", 64'(wr_drop), 64'h0);
    wr_addr = 5'd0;
    step();
    check("wr0_en", 64'(en_out), 64'h1);
    wr_addr = 5'd30;
    step();
    check("wr30_en", 64'(en_out), 64'h4000_0000);
    wr_en = 1'b0; wr_addr = 5'd4;
    step();
    check("no_wr_en", 64'(en_out), 64'h0);

    // clr_req beats a same-cycle write
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3;
    step();
    check("clr_en", 64'(en_out), 64'h0);
    check("clr_drop", 64'(wr_drop), 64'h1);
    check("clr_busy", 64'(busy), 64'h1);
    check("clr_clr_active", 64'(clr_active), 64'h0);
    clr_req = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      clr_req = (i == 5);
      step();
      check("resweep_en", 64'(en_out), 64'h1 << i);
      check("resweep_clr_active", 64'(clr_active), 64'h1);
      check("resweep_drop", 64'(wr_drop), 64'h0);
    end
    clr_req = 1'b0;
    step();
    check("resweep_done_en", 64'(en_out), 64'h0);
    check("resweep_done_busy", 64'(busy), 64'h0);

    // Async reset mid-sweep at cnt=17
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("pre_rst_en", 64'(en_out), 64'h1_0000);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_en", 64'(en_out), 64'h0);
    check("async_rst_clr_active", 64'(clr_active), 64'h0);
    check("async_rst_busy", 64'(busy), 64'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("restart_en0", 64'(en_out), 64'h1);
    step();
    check("restart_en1", 64'(en_out), 64'h2);

    // Small configuration: 6 registers, no zero mask
    @(negedge clk);
    reset2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("small_sweep_en", 64'(en_out2), 64'h1 << i);
      check("small_sweep_clr_active", 64'(clr_active2), 64'h1);
    end
    check("small_busy_done", 64'(busy2), 64'h0);
    wr_en2 = 1'b1; wr_addr2 = 3'd5;
    step();
    check("small_wr5", 64'(en_out2), 64'h20);
    check("small_wr5_drop", 64'(wr_drop2), 64'h0);
    wr_addr2 = 3'd7;
    step();
    check("small_wr7", 64'(en_out2), 64'h0);
    check("small_wr7_drop", 64'(wr_drop2), 64'h0);
    wr_addr2 = 3'd6;
    step();
    check("small_wr6", 64'(en_out2), 64'h0);
    wr_addr2 = 3'd0;
    step();
    check("small_wr0", 64'(en_out2), 64'h1);
    wr_en2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_wen_decoder
